// File: rtl/move_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// move_step_ctrl_pkg
// Shared definitions for the cube coordinate step controllers (X and Y axis):
//   - state_t          : step-controller FSM state encoding
//   - DEF_HOLD_FRAMES  : default frame ticks from first step to auto-repeat
//   - DEF_STEP_FRAMES  : default frame ticks between auto-repeat steps
//   - frame_cnt_width(): width of a saturating frame counter able to reach
//                        max(hold, step)
// -----------------------------------------------------------------------------
package move_step_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_DELAY,
    ST_REPEAT,
    ST_LOAD,
    ST_WAITREL
  } state_t;

  localparam int DEF_HOLD_FRAMES = 20;
  localparam int DEF_STEP_FRAMES = 4;

  function automatic int frame_cnt_width(input int hold_frames, input int step_frames);
    return $clog2(((hold_frames > step_frames) ? hold_frames : step_frames) + 1);
  endfunction

endpackage

// File: rtl/move_step_ctrl_btn_sync.sv
// -----------------------------------------------------------------------------
// move_step_ctrl_btn_sync
// Multi-flop synchronizer for one raw push-button level.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low clear
//   din   : raw asynchronous button level
//   dout  : level synchronized to clk, STAGES edges later
// -----------------------------------------------------------------------------
module move_step_ctrl_btn_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] q;

  // NOTE: synchronizer flops are cleared on reset so a button held through
  // reset is seen as a fresh press once it propagates through the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= {q[STAGES-2:0], din};
    end
  end

  assign dout = q[STAGES-1];

endmodule

// File: rtl/move_step_ctrl.sv
// -----------------------------------------------------------------------------
// move_step_ctrl
// Turns raw push-buttons into single-cycle UP / DW / LD strobes for the
// loadable 16-bit Y-coordinate counter. A press gives one immediate step;
// holding gives auto-repeat paced by frame ticks. Counter limit flags block
// motion past the ends so the coordinate never wraps.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   btnU/D/C   : raw up / down / load buttons (async, active-high)
//   frame_tick : one-clk pulse per video frame
//   at_top     : counter at upper bound, blocks UP
//   at_bottom  : counter at zero, blocks DW
//   UP/DW/LD   : registered, mutually exclusive one-clk strobes
//   moving     : high while a step sequence is in progress
// -----------------------------------------------------------------------------
module move_step_ctrl
  import move_step_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int STEP_FRAMES = DEF_STEP_FRAMES
) (
  input  logic clk,
  input  logic reset,
  input  logic btnU,
  input  logic btnD,
  input  logic btnC,
  input  logic frame_tick,
  input  logic at_top,
  input  logic at_bottom,
  output logic UP,
  output logic DW,
  output logic LD,
  output logic moving
);

  localparam int CW = frame_cnt_width(HOLD_FRAMES, STEP_FRAMES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_FRAMES);
  localparam logic [CW-1:0] STEP_C  = CW'(STEP_FRAMES);

  logic u, d, c;

  move_step_ctrl_btn_sync #(.STAGES(SYNC_STAGES)) u_sync_u (
    .clk(clk), .rst_n(reset), .din(btnU), .dout(u)
  );
  move_step_ctrl_btn_sync #(.STAGES(SYNC_STAGES)) u_sync_d (
    .clk(clk), .rst_n(reset), .din(btnD), .dout(d)
  );
  move_step_ctrl_btn_sync #(.STAGES(SYNC_STAGES)) u_sync_c (
    .clk(clk), .rst_n(reset), .din(btnC), .dout(c)
  );

  state_t        state;
  logic          dir;       // 1 = up, 0 = down; fixed for the whole press
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          drop;      // active button released, or both directions held
  logic          step_up;
  logic          step_dw;

  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    drop    = (dir ? !u : !d) | (u & d);
    // A step blocked by a limit is simply lost; the timing is unaffected.
    step_up = dir & !at_top;
    step_dw = !dir & !at_bottom;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      dir    <= 1'b0;
      cnt    <= '0;
      UP     <= 1'b0;
      DW     <= 1'b0;
      LD     <= 1'b0;
      moving <= 1'b0;
    end else begin
      // NOTE: strobes default low at every edge; a later non-blocking
      // assignment in the case below wins, giving exactly one-cycle pulses.
      UP <= 1'b0;
      DW <= 1'b0;
      LD <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (c) begin
            state <= ST_LOAD;
          end else if (u ^ d) begin
            state  <= ST_FIRST;
            dir    <= u;
            moving <= 1'b1;
          end
        end
        ST_FIRST, ST_DELAY, ST_REPEAT: begin
          if (c) begin
            state  <= ST_LOAD;
            moving <= 1'b0;
          end else if (drop) begin
            state  <= ST_IDLE;
            moving <= 1'b0;
          end else if (state == ST_FIRST) begin
            UP    <= step_up;
            DW    <= step_dw;
            cnt   <= '0;
            state <= ST_DELAY;
          end else if (frame_tick) begin
            if (state == ST_DELAY) begin
              if (cnt_inc == HOLD_C) begin
                state <= ST_REPEAT;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (cnt_inc == STEP_C) begin
              UP  <= step_up;
              DW  <= step_dw;
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_LOAD: begin
          LD    <= 1'b1;
          state <= ST_WAITREL;
        end
        ST_WAITREL: begin
          if (!(u | d | c)) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_move_step_ctrl
// Directed scenarios followed by randomized button/limit/reset phases. The
// reference model tracks a press as a session and decides steps from the
// cumulative number of frame ticks since the first step.
// -----------------------------------------------------------------------------
module tb_move_step_ctrl;

  localparam int SYNC        = 2;
  localparam int HOLD        = 3;
  localparam int STEP        = 2;
  localparam int TICK_PERIOD = 10;

  logic clk = 1'b0;
  logic reset, btnU, btnD, btnC, frame_tick, at_top, at_bottom;
  logic UP, DW, LD, moving;

  move_step_ctrl #(
    .SYNC_STAGES(SYNC),
    .HOLD_FRAMES(HOLD),
    .STEP_FRAMES(STEP)
  ) dut (
    .clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnC(btnC),
    .frame_tick(frame_tick), .at_top(at_top), .at_bottom(at_bottom),
    .UP(UP), .DW(DW), .LD(LD), .moving(moving)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [SYNC-1:0] hu, hd, hc;     // raw samples travelling to the FSM
  bit m_active, m_first, m_dir, m_loadp, m_wait;
  int m_ticks;                     // frame ticks counted since the first step
  bit e_up, e_dw, e_ld;
  int tick_phase;
  int n_up, n_dw, n_ld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hu = '0; hd = '0; hc = '0;
    m_active = 0; m_first = 0; m_dir = 0; m_loadp = 0; m_wait = 0;
    m_ticks = 0;
    e_up = 0; e_dw = 0; e_ld = 0;
  endtask

  task automatic model_step_out();
    if (m_dir && !at_top) e_up = 1;
    if (!m_dir && !at_bottom) e_dw = 1;
  endtask

  task automatic model_edge();
    bit su, sd, sc;
    if (!reset) begin
      model_reset();
      return;
    end
    su = hu[SYNC-1]; sd = hd[SYNC-1]; sc = hc[SYNC-1];
    e_up = 0; e_dw = 0; e_ld = 0;
    if (m_wait) begin
      if (!(su | sd | sc)) m_wait = 0;
    end else if (m_loadp) begin
      e_ld = 1; m_loadp = 0; m_wait = 1;
    end else if (m_active) begin
      if (sc) begin
        m_active = 0; m_loadp = 1;
      end else if ((m_dir ? !su : !sd) || (su && sd)) begin
        m_active = 0;
      end else if (m_first) begin
        model_step_out();
        m_first = 0; m_ticks = 0;
      end else if (frame_tick) begin
        m_ticks++;
        if (m_ticks > HOLD && ((m_ticks - HOLD) % STEP) == 0) model_step_out();
      end
    end else begin
      if (sc) m_loadp = 1;
      else if (su ^ sd) begin
        m_active = 1; m_first = 1; m_dir = su;
      end
    end
    hu = {hu[SYNC-2:0], btnU};
    hd = {hd[SYNC-2:0], btnD};
    hc = {hc[SYNC-2:0], btnC};
  endtask

  // One clock: present frame_tick, advance DUT and model, compare at negedge.
  task automatic cycle();
    frame_tick = (tick_phase == TICK_PERIOD - 1);
    tick_phase = (tick_phase + 1) % TICK_PERIOD;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("up", UP, e_up);
    check("dw", DW, e_dw);
    check("ld", LD, e_ld);
    check("moving", moving, m_active);
    check("strobe_excl", ($countones({UP, DW, LD}) <= 1), 1);
    n_up += int'(UP); n_dw += int'(DW); n_ld += int'(LD);
  endtask

  task automatic idle_all(input int n);
    btnU = 0; btnD = 0; btnC = 0;
    repeat (n) cycle();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_k, r, len;
    bit found, seen_ld;
    int up_after;
    int dw_at[$];

    reset = 0; btnU = 0; btnD = 0; btnC = 0; frame_tick = 0;
    at_top = 0; at_bottom = 0; tick_phase = 0;
    n_up = 0; n_dw = 0; n_ld = 0;
    model_reset();

    // Reset state
    repeat (3) cycle();
    check("rst_up", UP, 0);
    check("rst_moving", moving, 0);
    reset = 1;
    idle_all(5);

    // Tap btnU for 5 clocks: one UP, SYNC+2 edges after first sampling edge
    n_up = 0; n_dw = 0; n_ld = 0; first_k = 0;
    btnU = 1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (UP && first_k == 0) first_k = k;
    end
    idle_all(30);
    check("tap_latency", first_k, SYNC + 2);
    check("tap_up_count", n_up, 1);
    check("tap_dw_ld_count", n_dw + n_ld, 0);

    // Hold btnD for 100 clocks: first step, then after HOLD+STEP ticks, then every STEP
    btnD = 1;
    for (int k = 1; k <= 100; k++) begin
      cycle();
      if (DW) dw_at.push_back(k);
    end
    idle_all(10);
    check("hold_dw_count_ge3", (dw_at.size() >= 3), 1);
    if (dw_at.size() >= 3) begin
      check("hold_dw_first", dw_at[0], SYNC + 2);
      check("hold_dw_gap1_range",
            ((dw_at[1] - dw_at[0]) > (HOLD + STEP - 1) * TICK_PERIOD) &&
            ((dw_at[1] - dw_at[0]) <= (HOLD + STEP) * TICK_PERIOD), 1);
      for (int i = 2; i < dw_at.size(); i++)
        check("hold_dw_repeat_gap", dw_at[i] - dw_at[i-1], STEP * TICK_PERIOD);
    end

    // Hold btnU at the top limit: no UP, but moving while held
    n_up = 0;
    at_top = 1;
    btnU = 1;
    repeat (60) cycle();
    check("attop_moving", moving, 1);
    check("attop_up_count", n_up, 0);
    idle_all(10);
    at_top = 0;

    // Hold btnU, pulse btnC: one LD, no UP afterwards until everything released
    n_ld = 0; seen_ld = 0; up_after = 0;
    btnU = 1;
    repeat (40) cycle();
    btnC = 1;
    for (int k = 0; k < 33; k++) begin
      if (k == 3) btnC = 0;
      cycle();
      if (LD) seen_ld = 1;
      else if (seen_ld && UP) up_after++;
    end
    check("load_ld_count", n_ld, 1);
    check("load_up_after", up_after, 0);
    idle_all(10);

    // btnU and btnD together: nothing; release btnD -> UP after SYNC+2 edges
    n_up = 0; n_dw = 0;
    btnU = 1; btnD = 1;
    repeat (30) cycle();
    check("both_strobes", n_up + n_dw, 0);
    check("both_moving", moving, 0);
    btnD = 0; first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (UP && first_k == 0) first_k = k;
    end
    check("both_release_latency", first_k, SYNC + 2);
    idle_all(10);

    // Reset mid-REPEAT: outputs drop at once; held button then restarts with FIRST
    btnU = 1; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (e_up && m_ticks > HOLD) found = 1;
    end
    check("reached_repeat_step", found, 1);
    check("repeat_up_high", UP, 1);
    reset = 0;
    #1;
    check("async_rst_up", UP, 0);
    check("async_rst_moving", moving, 0);
    model_reset();
    cycle();
    reset = 1; first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (UP && first_k == 0) first_k = k;
    end
    check("post_rst_first_latency", first_k, SYNC + 2);
    idle_all(10);

    // Randomized phases of buttons, limits and occasional resets
    for (int p = 0; p < 80; p++) begin
      r = $urandom_range(0, 9);
      btnU = r inside {2, 3, 6, 8, 9};
      btnD = r inside {4, 5, 6};
      btnC = r inside {7, 8};
      at_top    = ($urandom_range(0, 3) == 0);
      at_bottom = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 14) == 0) reset = 0;
      len = $urandom_range(1, 40);
      repeat (len) cycle();
      reset = 1;
    end
    idle_all(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
